// File: rtl/fwd_scoreboard_if.sv
// EX-stage forwarding/hazard bus: EX instruction fields in, per-source selects and stall out.
// The optional stall counter (FWD_STALL_CNT_EN) is a plain port on fwd_scoreboard, not part of this bus.
interface fwd_scoreboard_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 2,
  parameter int DEPTH          = 3,
  parameter int LAT_WIDTH      = 2,
  parameter int SEL_WIDTH      = $clog2(DEPTH + 1)
);
  logic                              advance;
  logic                              flush;
  logic                              ex_regwrite;
  logic [REG_ADDR_WIDTH-1:0]         ex_rd;
  logic [LAT_WIDTH-1:0]              ex_lat;
  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] ex_rs;
  logic [NUM_SRC-1:0]                ex_rs_used;
  logic [NUM_SRC*SEL_WIDTH-1:0]      fwd_sel;
  logic                              stall;

  modport master (
    output advance, flush, ex_regwrite, ex_rd, ex_lat, ex_rs, ex_rs_used,
    input  fwd_sel, stall
  );

  modport slave (
    input  advance, flush, ex_regwrite, ex_rd, ex_lat, ex_rs, ex_rs_used,
    output fwd_sel, stall
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard scoreboard over DEPTH in-flight result stages (slot 0 = youngest).
// Optional feature macro FWD_STALL_CNT_EN adds a saturating stall_cnt output (CNT_WIDTH bits).
module fwd_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 2,
  parameter int DEPTH          = 3,
  parameter int LAT_WIDTH      = 2,
  parameter int SEL_WIDTH      = $clog2(DEPTH + 1)
`ifdef FWD_STALL_CNT_EN
  ,
  parameter int CNT_WIDTH      = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fwd_scoreboard_if.slave      bus
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  function automatic logic [LAT_WIDTH-1:0] sat_dec(input logic [LAT_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  logic [DEPTH-1:0]                     valid_q, valid_d;
  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][LAT_WIDTH-1:0]      cnt_q, cnt_d;

  logic [REG_ADDR_WIDTH-1:0] src_rs  [NUM_SRC];
  logic                      src_hit [NUM_SRC];
  logic [SEL_WIDTH-1:0]      src_sel [NUM_SRC];
  logic [LAT_WIDTH-1:0]      src_cnt [NUM_SRC];

  logic [NUM_SRC*SEL_WIDTH-1:0] fwd_sel_c;
  logic                         stall_raw;
  logic                         stall_c;
  logic                         record;

  // Lookup: scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fwd_sel_c = '0;
    stall_raw = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src_rs[k]  = bus.ex_rs[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      src_hit[k] = 1'b0;
      src_sel[k] = '0;
      src_cnt[k] = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (valid_q[i] && (rd_q[i] == src_rs[k])) begin
          src_hit[k] = 1'b1;
          src_sel[k] = SEL_WIDTH'(i + 1);
          src_cnt[k] = cnt_q[i];
        end
      end
      if (!bus.ex_rs_used[k] || (src_rs[k] == '0)) begin
        src_hit[k] = 1'b0;
        src_sel[k] = '0;
      end
      fwd_sel_c[k*SEL_WIDTH +: SEL_WIDTH] = src_sel[k];
      if (src_hit[k] && (src_cnt[k] != '0)) begin
        stall_raw = 1'b1;
      end
    end
  end

  // A flushed EX instruction is dead, so it must not hold the pipeline.
  assign stall_c     = stall_raw & ~bus.flush;
  assign bus.stall   = stall_c;
  assign bus.fwd_sel = fwd_sel_c;

  assign record = bus.ex_regwrite && (bus.ex_rd != '0) && !stall_c && !bus.flush;

  // Slot shift: only on advance; counts age as they move toward retirement.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (bus.advance) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_d[i] = valid_q[i-1];
        rd_d[i]    = rd_q[i-1];
        cnt_d[i]   = sat_dec(cnt_q[i-1]);
      end
      if (record) begin
        valid_d[0] = 1'b1;
        rd_d[0]    = bus.ex_rd;
        cnt_d[0]   = bus.ex_lat;
      end else begin
        valid_d[0] = 1'b0;
        rd_d[0]    = '0;
        cnt_d[0]   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && bus.advance) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus randomized traffic
// checked against an in-flight instruction list model (age counted in advances).
module tb_fwd_scoreboard;
  localparam int RW = 5;
  localparam int NS = 2;
  localparam int DP = 3;
  localparam int LW = 2;
  localparam int SW = $clog2(DP + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.REG_ADDR_WIDTH(RW), .NUM_SRC(NS), .DEPTH(DP),
                      .LAT_WIDTH(LW), .SEL_WIDTH(SW)) bus ();

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt;
  fwd_scoreboard #(.REG_ADDR_WIDTH(RW), .NUM_SRC(NS), .DEPTH(DP),
                   .LAT_WIDTH(LW), .SEL_WIDTH(SW), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt(stall_cnt));
`else
  fwd_scoreboard #(.REG_ADDR_WIDTH(RW), .NUM_SRC(NS), .DEPTH(DP),
                   .LAT_WIDTH(LW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: list of issued instructions, youngest first, with age in advances.
  typedef struct {
    bit v;
    int rd;
    int lat;
    int age;
  } ent_t;
  ent_t q[$];
  int   m_scnt = 0;

  function automatic int m_sel(input int k);
    int rs;
    rs = int'(bus.ex_rs[k*RW +: RW]);
    if (!bus.ex_rs_used[k] || rs == 0) return 0;
    foreach (q[i]) if (q[i].v && q[i].rd == rs) return i + 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    int s;
    if (bus.flush) return 1'b0;
    for (int k = 0; k < NS; k++) begin
      s = m_sel(k);
      if (s != 0 && (q[s-1].lat - q[s-1].age) > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void m_advance();
    bit   st;
    ent_t e;
    st = m_stall();
    if (!bus.advance) return;
    if (st) m_scnt++;
    foreach (q[i]) q[i].age++;
    e.v   = bus.ex_regwrite && (bus.ex_rd != 0) && !st && !bus.flush;
    e.rd  = e.v ? int'(bus.ex_rd) : 0;
    e.lat = e.v ? int'(bus.ex_lat) : 0;
    e.age = 0;
    q.push_front(e);
    if (q.size() > DP) void'(q.pop_back());
  endfunction

  task automatic compare();
    @(negedge clk);
    for (int k = 0; k < NS; k++)
      chk($sformatf("sel%0d", k), 32'(bus.fwd_sel[k*SW +: SW]), m_sel(k));
    chk("stall", 32'(bus.stall), 32'(m_stall()));
`ifdef FWD_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_scnt);
`endif
  endtask

  task automatic step();
    compare();
    @(posedge clk);
    m_advance();
    #1;
  endtask

  task automatic set(input bit rw, input int rd, input int lat, input int rs0, input int rs1,
                     input bit [1:0] used, input bit adv, input bit fl);
    bus.ex_regwrite = rw;
    bus.ex_rd       = RW'(rd);
    bus.ex_lat      = LW'(lat);
    bus.ex_rs       = {RW'(rs1), RW'(rs0)};
    bus.ex_rs_used  = used;
    bus.advance     = adv;
    bus.flush       = fl;
  endtask

  task automatic expect_now(input string tag, input int k, input int sel, input bit st);
    #1;
    chk({tag, "_sel"}, 32'(bus.fwd_sel[k*SW +: SW]), sel);
    chk({tag, "_stall"}, 32'(bus.stall), 32'(st));
  endtask

`ifdef FWD_STALL_CNT_EN
  logic [31:0] scnt_base;
`endif

  initial begin
    set(0, 0, 0, 0, 0, 2'b00, 0, 0);
    #3;
    set(0, 0, 0, 3, 4, 2'b11, 0, 0);
    expect_now("reset", 0, 0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set(0, 0, 0, 0, 0, 2'b00, 0, 0);

    // ALU chain
    set(1, 5, 0, 0, 0, 2'b00, 1, 0); step();
    set(0, 0, 0, 5, 0, 2'b01, 1, 0);
    expect_now("alu_s0", 0, 1, 1'b0);
    step(); expect_now("alu_s1", 0, 2, 1'b0);
    step(); expect_now("alu_s2", 0, 3, 1'b0);
    step(); expect_now("alu_rf", 0, 0, 1'b0);

    // Load-use with hold
    set(1, 6, 1, 0, 0, 2'b00, 1, 0); step();
    set(0, 0, 0, 0, 6, 2'b10, 0, 0);
    expect_now("lu", 1, 1, 1'b1);
    repeat (3) begin
      step(); expect_now("lu_hold", 1, 1, 1'b1);
    end
    bus.advance = 1'b1;
    step(); expect_now("lu_clear", 1, 2, 1'b0);

    // Shadowing and x0
    set(1, 7, 0, 0, 0, 2'b00, 1, 0); step(); step();
    set(0, 0, 0, 7, 0, 2'b01, 0, 0);
    expect_now("shadow", 0, 1, 1'b0);
    set(1, 0, 0, 0, 0, 2'b00, 1, 0); step();
    set(0, 0, 0, 0, 7, 2'b11, 0, 0);
    expect_now("x0_src", 0, 0, 1'b0);
    expect_now("x0_bubble", 1, 2, 1'b0);

    // Flush during load-use
    set(1, 9, 1, 0, 0, 2'b00, 1, 0); step();
    set(1, 10, 0, 9, 0, 2'b01, 0, 1);
    expect_now("flush", 0, 1, 1'b0);
    step(); expect_now("flush_hold", 0, 1, 1'b0);
    bus.advance = 1'b1;
    step();
    set(0, 0, 0, 9, 10, 2'b11, 0, 0);
    expect_now("flush_ld", 0, 2, 1'b0);
    expect_now("flush_bub", 1, 0, 1'b0);

    // lat=2 producer stalls dependent for two advances
`ifdef FWD_STALL_CNT_EN
    scnt_base = stall_cnt;
`endif
    set(1, 11, 2, 0, 0, 2'b00, 1, 0); step();
    set(0, 0, 0, 11, 0, 2'b01, 1, 0);
    expect_now("lat2_a", 0, 1, 1'b1);
    step(); expect_now("lat2_b", 0, 2, 1'b1);
    step(); expect_now("lat2_c", 0, 3, 1'b0);
`ifdef FWD_STALL_CNT_EN
    chk("lat2_cnt", stall_cnt - scnt_base, 2);
`endif

    // Asynchronous reset mid-stall
    set(1, 12, 1, 0, 0, 2'b00, 1, 0); step();
    set(0, 0, 0, 12, 0, 2'b01, 0, 0);
    #1 chk("pre_rst_stall", 32'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'(bus.fwd_sel[0 +: SW]), 0);
    chk("rst_stall", 32'(bus.stall), 0);
`ifdef FWD_STALL_CNT_EN
    chk("rst_cnt", stall_cnt, 0);
`endif
    q.delete();
    m_scnt = 0;
    #1 rst_n = 1'b1;
    step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      set(($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 3),
          $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
